// File: rtl/bus_transfer_scheduler.sv
// ---------------------------------------------------------------------------
// bus_transfer_scheduler
//
// Queues register-transfer commands (source agent, destination agent) coming
// from the control sequencer and issues them onto the shared internal bus,
// one transfer per clock. Each issued transfer drives a one-hot out-enable
// (bus source select) and a one-hot in-enable (destination register load)
// for exactly one cycle. Transfers sourced from MDR are held back until
// memory data is ready.
//
// Agent codes: 0-15 R0-R15, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR,
// 22 InPort, 23 C. Codes 24-31 are illegal and are rejected at the input.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-high reset, clears all state
//   flush       in   synchronous; empties the queue and returns to idle
//   cmd_valid   in   command present
//   cmd_ready   out  queue can accept a command (not full)
//   cmd_src     in   5-bit source agent code
//   cmd_dst     in   5-bit destination agent code
//   mem_ready   in   MDR holds valid read data
//   src_out     out  NSRC-bit one-hot bus out-enable
//   dst_in      out  NSRC-bit one-hot register in-enable
//   busy        out  queue non-empty or a transfer stalled/issuing
//   cmd_err     out  one-cycle pulse after an illegal command is dropped
//   issued_cnt  out  16-bit saturating count of issue cycles
//   stall_cnt   out  16-bit saturating count of MDR stall cycles
//
// Optional feature macro: BUS_SCHED_PERF_EN
//   When defined, issued_cnt and stall_cnt are live saturating counters
//   cleared only by reset. When undefined they are tied to zero.
// ---------------------------------------------------------------------------
module bus_transfer_scheduler #(
  parameter int DEPTH = 4,
  parameter int NSRC  = 24
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [4:0]      cmd_src,
  input  logic [4:0]      cmd_dst,
  input  logic            mem_ready,
  output logic [NSRC-1:0] src_out,
  output logic [NSRC-1:0] dst_in,
  output logic            busy,
  output logic            cmd_err,
  output logic [15:0]     issued_cnt,
  output logic [15:0]     stall_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [4:0] MDR_CODE      = 5'd21;
  localparam logic [4:0] FIRST_ILLEGAL = 5'd24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  // Decode an agent code into its one-hot enable vector.
  function automatic logic [NSRC-1:0] decode_onehot(input logic [4:0] code);
    decode_onehot = {{(NSRC-1){1'b0}}, 1'b1} << code;
  endfunction

  // Command queue storage; the extra pointer bit separates full from empty.
  logic [9:0]    fifo_mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;

  state_t        state_r;
  state_t        state_nxt_s;

  logic [NSRC-1:0] src_out_r;
  logic [NSRC-1:0] dst_in_r;
  logic [NSRC-1:0] src_nxt_s;
  logic [NSRC-1:0] dst_nxt_s;
  logic            cmd_err_r;

  logic          empty_s;
  logic          full_s;
  logic          legal_s;
  logic          accept_s;
  logic          push_s;
  logic          reject_s;
  logic          pop_s;
  logic [9:0]    head_s;
  logic [4:0]    head_src_s;
  logic [4:0]    head_dst_s;

  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign head_s     = fifo_mem_r[rd_ptr_r[AW-1:0]];
  assign head_src_s = head_s[9:5];
  assign head_dst_s = head_s[4:0];

  // A command arriving alongside flush is discarded, so it is neither
  // queued nor reported as an error.
  assign legal_s  = (cmd_src < FIRST_ILLEGAL) && (cmd_dst < FIRST_ILLEGAL);
  assign accept_s = cmd_valid && !full_s && !flush;
  assign push_s   = accept_s && legal_s;
  assign reject_s = accept_s && !legal_s;

  assign cmd_ready = !full_s;
  assign busy      = !empty_s || (state_r != ST_IDLE);
  assign src_out   = src_out_r;
  assign dst_in    = dst_in_r;
  assign cmd_err   = cmd_err_r;

  // Issue FSM state register and registered bus strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      src_out_r <= {NSRC{1'b0}};
      dst_in_r  <= {NSRC{1'b0}};
      cmd_err_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      src_out_r <= src_nxt_s;
      dst_in_r  <= dst_in_nxt_guard(dst_nxt_s);
      cmd_err_r <= reject_s;
    end
  end

  // Identity helper keeps the strobe path explicit in the register block.
  function automatic logic [NSRC-1:0] dst_in_nxt_guard(input logic [NSRC-1:0] v);
    dst_in_nxt_guard = v;
  endfunction

  // Next-state logic. ISSUE re-evaluates the head exactly like IDLE so that
  // consecutive commands issue back to back without an idle bubble.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_ISSUE: begin
        if (!empty_s) begin
          if ((head_src_s == MDR_CODE) && !mem_ready) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_ISSUE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    if (flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // Output logic: the head is popped on the edge that enters ISSUE and its
  // decoded strobes are loaded into the output registers on that same edge.
  always_comb begin
    pop_s     = 1'b0;
    src_nxt_s = {NSRC{1'b0}};
    dst_nxt_s = {NSRC{1'b0}};
    if ((state_nxt_s == ST_ISSUE) && !empty_s) begin
      pop_s     = 1'b1;
      src_nxt_s = decode_onehot(head_src_s);
      dst_nxt_s = decode_onehot(head_dst_s);
    end else begin
      pop_s     = 1'b0;
    end
  end

  // Command queue pointers and storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_r[i] <= 10'd0;
      end
    end else if (flush) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r[AW-1:0]] <= {cmd_src, cmd_dst};
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

`ifdef BUS_SCHED_PERF_EN
  logic [15:0] issued_cnt_r;
  logic [15:0] stall_cnt_r;

  // Saturating performance counters; flush leaves them untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issued_cnt_r <= 16'd0;
      stall_cnt_r  <= 16'd0;
    end else begin
      if ((state_r == ST_ISSUE) && (issued_cnt_r != 16'hFFFF)) begin
        issued_cnt_r <= issued_cnt_r + 16'd1;
      end
      if ((state_r == ST_WAIT) && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end
    end
  end

  assign issued_cnt = issued_cnt_r;
  assign stall_cnt  = stall_cnt_r;
`else
  assign issued_cnt = 16'd0;
  assign stall_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_bus_transfer_scheduler.sv
// ---------------------------------------------------------------------------
// Self-checking bench for bus_transfer_scheduler. A transaction-level model
// (queue of pending commands plus per-cycle expected strobes) predicts every
// output after each clock edge; directed scenarios are followed by a random
// phase.
// ---------------------------------------------------------------------------
module tb_bus_transfer_scheduler;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_src;
  logic [4:0]  cmd_dst;
  logic        mem_ready;
  logic [23:0] src_out;
  logic [23:0] dst_in;
  logic        busy;
  logic        cmd_err;
  logic [15:0] issued_cnt;
  logic [15:0] stall_cnt;

  bus_transfer_scheduler #(.DEPTH(DEPTH), .NSRC(24)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .mem_ready(mem_ready),
    .src_out(src_out), .dst_in(dst_in), .busy(busy), .cmd_err(cmd_err),
    .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [9:0]  q[$];
  logic [23:0] m_src, m_dst;
  bit          m_issue, m_wait, m_err;
  int          m_issued, m_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] onehot(input int c);
    logic [23:0] v;
    v = 24'd0;
    v[c] = 1'b1;
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_update();
    bit rdy;
    rdy = (q.size() < DEPTH);
    if (m_issue && m_issued < 65535) m_issued++;
    if (m_wait && m_stall < 65535) m_stall++;
    m_issue = 0; m_wait = 0; m_err = 0;
    m_src = 24'd0; m_dst = 24'd0;
    if (flush) begin
      q.delete();
    end else begin
      if (q.size() > 0) begin
        if (q[0][9:5] == 5'd21 && !mem_ready) begin
          m_wait = 1;
        end else begin
          m_issue = 1;
          m_src = onehot(int'(q[0][9:5]));
          m_dst = onehot(int'(q[0][4:0]));
          void'(q.pop_front());
        end
      end
      if (cmd_valid && rdy) begin
        if (cmd_src > 5'd23 || cmd_dst > 5'd23) m_err = 1;
        else q.push_back({cmd_src, cmd_dst});
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_src"}, 32'(src_out), 32'(m_src));
    check({tag, "_dst"}, 32'(dst_in), 32'(m_dst));
    check({tag, "_ready"}, 32'(cmd_ready), 32'(q.size() < DEPTH));
    check({tag, "_busy"}, 32'(busy), 32'(q.size() > 0 || m_issue || m_wait));
    check({tag, "_err"}, 32'(cmd_err), 32'(m_err));
`ifdef BUS_SCHED_PERF_EN
    check({tag, "_icnt"}, 32'(issued_cnt), 32'(m_issued));
    check({tag, "_scnt"}, 32'(stall_cnt), 32'(m_stall));
`else
    check({tag, "_icnt"}, 32'(issued_cnt), 32'd0);
    check({tag, "_scnt"}, 32'(stall_cnt), 32'd0);
`endif
  endtask

  task automatic cycle(input string tag);
    model_update();
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic push(input logic [4:0] s, input logic [4:0] d, input string tag);
    cmd_valid = 1'b1; cmd_src = s; cmd_dst = d;
    cycle(tag);
    cmd_valid = 1'b0;
  endtask

  task automatic model_clear();
    q.delete();
    m_src = 24'd0; m_dst = 24'd0;
    m_issue = 0; m_wait = 0; m_err = 0;
    m_issued = 0; m_stall = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; cmd_valid = 1'b0;
    cmd_src = 5'd0; cmd_dst = 5'd0;
    model_clear();
    #1;
    check("rst_src", 32'(src_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_all("rst");
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; cmd_valid = 1'b0; mem_ready = 1'b1;
    cmd_src = 5'd0; cmd_dst = 5'd0;
    model_clear();

    // Single transfer R4 -> Zlow
    do_reset();
    mem_ready = 1'b1;
    push(5'd4, 5'd19, "t1_push");
    cycle("t1_issue");
    check("t1_src_const", 32'(src_out), 32'h000010);
    check("t1_dst_const", 32'(dst_in), 32'h080000);
    cycle("t1_after");
    check("t1_busy_low", 32'(busy), 32'd0);

    // Fill behind a stalled MDR head, then drain back to back
    do_reset();
    mem_ready = 1'b0;
    push(5'd21, 5'd5, "t2_p0");
    push(5'd1, 5'd2, "t2_p1");
    push(5'd2, 5'd3, "t2_p2");
    push(5'd16, 5'd0, "t2_p3");
    check("t2_full_ready", 32'(cmd_ready), 32'd0);
    push(5'd20, 5'd21, "t2_rejfull");
    mem_ready = 1'b1;
    push(5'd20, 5'd21, "t2_p4");
    for (int i = 0; i < 6; i++) cycle("t2_drain");

    // MDR stall: three stall cycles, then the strobe
    do_reset();
    mem_ready = 1'b0;
    push(5'd21, 5'd20, "t3_push");
    for (int i = 0; i < 3; i++) cycle("t3_wait");
    mem_ready = 1'b1;
    cycle("t3_issue");
    check("t3_src_const", 32'(src_out), 32'h200000);
    check("t3_dst_const", 32'(dst_in), 32'h100000);
`ifdef BUS_SCHED_PERF_EN
    check("t3_stall3", 32'(stall_cnt), 32'd3);
`endif
    cycle("t3_after");

    // Illegal codes are dropped with a one-cycle error pulse
    do_reset();
    push(5'd25, 5'd3, "t4_ill_src");
    check("t4_err_const", 32'(cmd_err), 32'd1);
    check("t4_busy_const", 32'(busy), 32'd0);
    push(5'd3, 5'd30, "t4_ill_dst");
    cycle("t4_after");
    push(5'd7, 5'd7, "t4_same");
    cycle("t4_same_issue");

    // Flush with queued commands and a simultaneous new command
    do_reset();
    mem_ready = 1'b0;
    push(5'd21, 5'd1, "t5_p0");
    push(5'd2, 5'd3, "t5_p1");
    push(5'd4, 5'd5, "t5_p2");
    flush = 1'b1;
    push(5'd6, 5'd7, "t5_flush");
    flush = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle("t5_post");
    check("t5_busy_const", 32'(busy), 32'd0);

    // Asynchronous reset while a strobe is on the bus
    do_reset();
    mem_ready = 1'b1;
    push(5'd7, 5'd8, "t6_push");
    push(5'd9, 5'd10, "t6_push2");
    check("t6_src_const", 32'(src_out), 32'h000080);
    #3;
    reset = 1'b1;
    #1;
    check("t6_async_src", 32'(src_out), 32'd0);
    check("t6_async_dst", 32'(dst_in), 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    model_clear();
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_all("t6_post");

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(9, 0) < 6);
      if ($urandom_range(9, 0) == 0) cmd_src = 5'($urandom_range(31, 24));
      else if ($urandom_range(4, 0) == 0) cmd_src = 5'd21;
      else cmd_src = 5'($urandom_range(23, 0));
      if ($urandom_range(19, 0) == 0) cmd_dst = 5'($urandom_range(31, 24));
      else cmd_dst = 5'($urandom_range(23, 0));
      mem_ready = ($urandom_range(9, 0) < 7);
      flush = ($urandom_range(99, 0) < 3);
      cycle("rnd");
    end
    cmd_valid = 1'b0; flush = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle("rnd_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
